// File: rtl/lsu_pkg.sv
// Shared decode helpers for the load/store unit: funct3 codes, FSM states
// and access-size lookups.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {ST_IDLE, ST_SECOND} state_t;

    function automatic logic [3:0] size_be(input logic [1:0] sz);
        case (sz)
            2'b00:   size_be = 4'b0001;
            2'b01:   size_be = 4'b0011;
            default: size_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we) is_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else    is_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-beat bundle. master = requester plus memory,
// slave = the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_we, mem_be, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_we, mem_be, mem_wd
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store data/enables shifted into a two-word window,
// load data shifted down from a two-word window and extended.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]              off,
    input  logic [2:0]              funct3,
    input  logic [DATA_WIDTH-1:0]   st_data,
    output logic [2*DATA_WIDTH-1:0] st_wd,
    output logic [7:0]              st_be,
    input  logic [2*DATA_WIDTH-1:0] ld_raw,
    output logic [DATA_WIDTH-1:0]   ld_data
);
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   mask;
    logic [2*DATA_WIDTH-1:0] sh;

    always_comb begin
        be   = size_be(funct3[1:0]);
        mask = '0;
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
        // Bytes above the access size are zeroed so lanes outside mem_be stay clean.
        st_wd = {{DATA_WIDTH{1'b0}}, st_data & mask} << {off, 3'b000};
        st_be = {4'b0000, be} << off;
        sh    = ld_raw >> {off, 3'b000};
        case (funct3)
            F3_B:    ld_data = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            F3_H:    ld_data = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            F3_BU:   ld_data = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            F3_HU:   ld_data = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: ld_data = sh[DATA_WIDTH-1:0];
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory beat per aligned access, two beats for
// word-crossing accesses, registered response one cycle after the last beat.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic            clk,
    input  logic            rst,
    load_store_unit_if.slave bus
);
    localparam logic ALLOW = (ALLOW_MISALIGNED != 0);

    state_t                  state, state_nx;
    logic [1:0]              off, off_q, al_off;
    logic [2:0]              f3_q, al_f3;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   word_addr, addr_q;
    logic [DATA_WIDTH-1:0]   lo_q, hi_wd_q, ld_data;
    logic [3:0]              hi_be_q;
    logic [2*DATA_WIDTH-1:0] st_wd, al_raw;
    logic [7:0]              st_be;
    logic                    legal, crossing, err, split, acc;

    assign bus.req_ready = (state == ST_IDLE) && !rst;

    always_comb begin
        off       = bus.req_addr[1:0];
        word_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        legal     = is_legal(bus.req_we, bus.req_funct3);
        crossing  = ({1'b0, off} + size_bytes(bus.req_funct3[1:0])) > 3'd4;
        err       = !legal || (crossing && !ALLOW);
        split     = legal && crossing && ALLOW;
        acc       = bus.req_valid && bus.req_ready;
    end

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .off     (al_off),
        .funct3  (al_f3),
        .st_data (bus.req_wdata),
        .st_wd   (st_wd),
        .st_be   (st_be),
        .ld_raw  (al_raw),
        .ld_data (ld_data)
    );

    always_comb begin
        state_nx     = state;
        bus.mem_addr = word_addr;
        bus.mem_we   = 1'b0;
        bus.mem_be   = 4'b0000;
        bus.mem_wd   = st_wd[DATA_WIDTH-1:0];
        al_off       = off;
        al_f3        = bus.req_funct3;
        al_raw       = {{DATA_WIDTH{1'b0}}, bus.mem_rd};
        case (state)
            ST_IDLE: begin
                if (acc) begin
                    bus.mem_we = bus.req_we && !err;
                    bus.mem_be = bus.mem_we ? st_be[3:0] : 4'b0000;
                    if (split) state_nx = ST_SECOND;
                end
            end
            ST_SECOND: begin
                // Upper word of a crossing access; address wraps at the top of memory.
                bus.mem_addr = addr_q + ADDR_WIDTH'(4);
                bus.mem_we   = we_q && !rst;
                bus.mem_be   = bus.mem_we ? hi_be_q : 4'b0000;
                bus.mem_wd   = hi_wd_q;
                al_off       = off_q;
                al_f3        = f3_q;
                al_raw       = {bus.mem_rd, lo_q};
                state_nx     = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            off_q          <= '0;
            f3_q           <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            lo_q           <= '0;
            hi_wd_q        <= '0;
            hi_be_q        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            state          <= state_nx;
            bus.resp_valid <= 1'b0;
            if (state == ST_IDLE && acc) begin
                off_q   <= off;
                f3_q    <= bus.req_funct3;
                we_q    <= bus.req_we;
                addr_q  <= word_addr;
                lo_q    <= bus.mem_rd;
                hi_wd_q <= st_wd[2*DATA_WIDTH-1:DATA_WIDTH];
                hi_be_q <= st_be[7:4];
                if (!split) begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= err;
                    bus.resp_rdata <= (err || bus.req_we) ? '0 : ld_data;
                end
            end else if (state == ST_SECOND) begin
                bus.resp_valid <= 1'b1;
                bus.resp_err   <= 1'b0;
                bus.resp_rdata <= we_q ? '0 : ld_data;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table through a response
// scoreboard, plus hand sequences for split beats, errors and reset.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ALLOW_MISALIGNED(0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    // Memory model: 16 words at 0x100..0x13F, everything else reads 0.
    logic [31:0] mem [0:15];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h44332211;
            mem[1] <= 32'h88776655;
        end else if (bus.mem_we && bus.mem_addr[31:6] == 26'h4) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) mem[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wd[8*b +: 8];
        end
    end

    always_comb begin
        bus.mem_rd = 32'h0;
        if (bus.mem_addr[31:6] == 26'h4) bus.mem_rd = mem[bus.mem_addr[5:2]];
    end

    always_comb begin
        bus2.mem_rd = 32'h0;
        if (bus2.mem_addr[31:6] == 26'h4) bus2.mem_rd = mem[bus2.mem_addr[5:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          c0;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (bus.resp_valid) begin
            if (sb.size() == 0) chk("unexpected resp_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rd);
                chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
                chk("latency", cyc - e.c0, e.lat);
            end
        end
    end

    task automatic issue(input vec_t v, input bit expect_resp,
                         output logic [31:0] a, output logic we,
                         output logic [3:0] be, output logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        #1;
        chk("req_ready at issue", {31'b0, bus.req_ready}, 32'd1);
        a  = bus.mem_addr;
        we = bus.mem_we;
        be = bus.mem_be;
        wd = bus.mem_wd;
        if (expect_resp) begin
            e.rd = v.rdata; e.err = v.err; e.lat = v.lat; e.c0 = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            chk("response timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic beat2(output logic [31:0] a, output logic we,
                         output logic [3:0] be, output logic [31:0] wd,
                         output logic rdy);
        @(negedge clk);
        #1;
        a = bus.mem_addr; we = bus.mem_we; be = bus.mem_be; wd = bus.mem_wd;
        rdy = bus.req_ready;
    endtask

    vec_t tbl [20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd;
        logic        we, rdy;
        logic [3:0]  be;
        vec_t        v;

        tbl[0]  = '{1'b0, F3_W,   32'h100, 32'h0,        32'h44332211, 1'b0, 1};
        tbl[1]  = '{1'b0, F3_H,   32'h106, 32'h0,        32'hFFFF8877, 1'b0, 1};
        tbl[2]  = '{1'b0, F3_HU,  32'h106, 32'h0,        32'h00008877, 1'b0, 1};
        tbl[3]  = '{1'b0, F3_B,   32'h103, 32'h0,        32'h00000044, 1'b0, 1};
        tbl[4]  = '{1'b0, F3_BU,  32'h107, 32'h0,        32'h00000088, 1'b0, 1};
        tbl[5]  = '{1'b0, F3_B,   32'h107, 32'h0,        32'hFFFFFF88, 1'b0, 1};
        tbl[6]  = '{1'b0, F3_H,   32'h100, 32'h0,        32'h00002211, 1'b0, 1};
        tbl[7]  = '{1'b0, F3_W,   32'h102, 32'h0,        32'h66554433, 1'b0, 2};
        tbl[8]  = '{1'b0, F3_H,   32'h103, 32'h0,        32'h00005544, 1'b0, 2};
        tbl[9]  = '{1'b0, F3_HU,  32'h107, 32'h0,        32'h00000088, 1'b0, 2};
        tbl[10] = '{1'b0, F3_W,   32'h105, 32'h0,        32'h00887766, 1'b0, 2};
        tbl[11] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 1};
        tbl[12] = '{1'b0, 3'b110, 32'h104, 32'h0,        32'h0,        1'b1, 1};
        tbl[13] = '{1'b1, 3'b100, 32'h100, 32'h000000AB, 32'h0,        1'b1, 1};
        tbl[14] = '{1'b1, F3_W,   32'h108, 32'hCAFEF00D, 32'h0,        1'b0, 1};
        tbl[15] = '{1'b0, F3_W,   32'h108, 32'h0,        32'hCAFEF00D, 1'b0, 1};
        tbl[16] = '{1'b1, F3_B,   32'h109, 32'h12345677, 32'h0,        1'b0, 1};
        tbl[17] = '{1'b0, F3_W,   32'h108, 32'h0,        32'hCAFE770D, 1'b0, 1};
        tbl[18] = '{1'b1, F3_H,   32'h10A, 32'hFFFF1234, 32'h0,        1'b0, 1};
        tbl[19] = '{1'b0, F3_W,   32'h108, 32'h0,        32'h1234770D, 1'b0, 1};

        // Reset state, with a store request held against the unit.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
        bus.req_addr = 32'h100; bus.req_wdata = 32'hDEADBEEF;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = F3_W;
        bus2.req_addr = 32'h0; bus2.req_wdata = 32'h0;
        #1;
        chk("reset req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("reset resp_rdata", bus.resp_rdata, 32'd0);
        chk("reset resp_err", {31'b0, bus.resp_err}, 32'd0);
        chk("reset mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("reset mem_be", {28'b0, bus.mem_be}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        preload = 1'b0;

        for (int i = 0; i < 20; i++) begin
            issue(tbl[i], 1'b1, a, we, be, wd);
            if (tbl[i].err) chk($sformatf("vec%0d err no write", i), {31'b0, we}, 32'd0);
            drain();
        end

        // Split load beats and ready deassertion in the second beat.
        v = '{1'b0, F3_W, 32'h102, 32'h0, 32'h66554433, 1'b0, 2};
        issue(v, 1'b1, a, we, be, wd);
        chk("lw102 beat1 addr", a, 32'h100);
        chk("lw102 beat1 we", {31'b0, we}, 32'd0);
        beat2(a, we, be, wd, rdy);
        chk("lw102 beat2 addr", a, 32'h104);
        chk("lw102 beat2 ready", {31'b0, rdy}, 32'd0);
        drain();

        // Address wrap on the second beat.
        v = '{1'b0, F3_W, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b0, 2};
        issue(v, 1'b1, a, we, be, wd);
        chk("wrap beat1 addr", a, 32'hFFFFFFFC);
        beat2(a, we, be, wd, rdy);
        chk("wrap beat2 addr", a, 32'h00000000);
        drain();

        // Back-to-back: next request accepted while the response pulses.
        v = '{1'b0, F3_W, 32'h104, 32'h0, 32'h88776655, 1'b0, 1};
        issue(v, 1'b1, a, we, be, wd);
        chk("b2b resp_valid", {31'b0, bus.resp_valid}, 32'd1);
        v = '{1'b0, F3_BU, 32'h100, 32'h0, 32'h00000011, 1'b0, 1};
        issue(v, 1'b1, a, we, be, wd);
        drain();

        // No-misalign instance: crossing access is an error with no beat.
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_funct3 = F3_W; bus2.req_addr = 32'h102;
        #1;
        chk("nomis ready", {31'b0, bus2.req_ready}, 32'd1);
        chk("nomis lw mem_we", {31'b0, bus2.mem_we}, 32'd0);
        @(posedge clk);
        #1 bus2.req_we = 1'b1; bus2.req_wdata = 32'h11223344;
        @(negedge clk);
        chk("nomis lw resp_valid", {31'b0, bus2.resp_valid}, 32'd1);
        chk("nomis lw resp_err", {31'b0, bus2.resp_err}, 32'd1);
        chk("nomis lw resp_rdata", bus2.resp_rdata, 32'd0);
        #1;
        chk("nomis sw mem_we", {31'b0, bus2.mem_we}, 32'd0);
        @(posedge clk);
        #1 bus2.req_we = 1'b0; bus2.req_addr = 32'h100;
        @(negedge clk);
        chk("nomis sw resp_err", {31'b0, bus2.resp_err}, 32'd1);
        @(posedge clk);
        #1 bus2.req_valid = 1'b0;
        @(negedge clk);
        chk("nomis aligned resp_err", {31'b0, bus2.resp_err}, 32'd0);
        chk("nomis aligned rdata", bus2.resp_rdata, 32'h44332211);
        @(negedge clk);
        chk("nomis resp one cycle", {31'b0, bus2.resp_valid}, 32'd0);

        // Split halfword store.
        v = '{1'b1, F3_H, 32'h103, 32'h0000BEEF, 32'h0, 1'b0, 2};
        issue(v, 1'b1, a, we, be, wd);
        chk("sh beat1 addr", a, 32'h100);
        chk("sh beat1 we", {31'b0, we}, 32'd1);
        chk("sh beat1 be", {28'b0, be}, 32'b1000);
        chk("sh beat1 wd", {24'b0, wd[31:24]}, 32'hEF);
        beat2(a, we, be, wd, rdy);
        chk("sh beat2 addr", a, 32'h104);
        chk("sh beat2 we", {31'b0, we}, 32'd1);
        chk("sh beat2 be", {28'b0, be}, 32'b0001);
        chk("sh beat2 wd", {24'b0, wd[7:0]}, 32'hBE);
        drain();
        chk("sh mem 0x100", mem[0], 32'hEF332211);
        chk("sh mem 0x104", mem[1], 32'h887766BE);
        v = '{1'b0, F3_W, 32'h104, 32'h0, 32'h887766BE, 1'b0, 1};
        issue(v, 1'b1, a, we, be, wd);
        drain();

        // Reset in the middle of a split store.
        v = '{1'b1, F3_W, 32'h101, 32'hAABBCCDD, 32'h0, 1'b0, 2};
        issue(v, 1'b0, a, we, be, wd);
        chk("rst sw beat1 be", {28'b0, be}, 32'b1110);
        rst = 1'b1;
        #1;
        chk("rst mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst mem_be", {28'b0, bus.mem_be}, 32'd0);
        chk("rst ready", {31'b0, bus.req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst mem 0x100", mem[0], 32'hBBCCDD11);
        chk("rst mem 0x104", mem[1], 32'h887766BE);
        v = '{1'b0, F3_W, 32'h100, 32'h0, 32'hBBCCDD11, 1'b0, 1};
        issue(v, 1'b1, a, we, be, wd);
        drain();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
